// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video pipeline constants, sprite shadow type and width helper
package video_pkg;

  localparam int HV_W            = 10;
  localparam int COLOR_W_DEFAULT = 6;
  localparam int SPRITE_LATENCY  = 3;
  localparam int H_VISIBLE       = 640;
  localparam int V_VISIBLE       = 480;

  typedef struct packed {
    logic [HV_W-1:0] x;
    logic [HV_W-1:0] y;
    logic            en;
    logic            flip;
  } sprite_shadow_t;

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sprite_anim_counter.sv
// rtl/sprite_anim_counter.sv - per-frame animation tick and frame index counter
module sprite_anim_counter
  import video_pkg::*;
#(
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic                           anim_en,
  output logic [clog2_min1(FRAMES)-1:0]  frame_idx
);

  localparam int IDX_W  = clog2_min1(FRAMES);
  localparam int TICK_W = clog2_min1(FRAME_TICKS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAMES - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  frame_idx_q, frame_idx_d;

  always_comb begin
    tick_d      = tick_q;
    frame_idx_d = frame_idx_q;
    if (frame_start && anim_en) begin
      if (tick_q == LAST_TICK) begin
        tick_d      = '0;
        frame_idx_d = (frame_idx_q == LAST_IDX) ? '0 : frame_idx_q + IDX_W'(1);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= '0;
      frame_idx_q <= '0;
    end else begin
      tick_q      <= tick_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  assign frame_idx = frame_idx_q;

endmodule

// File: rtl/sprite_drawer.sv
// rtl/sprite_drawer.sv - movable, animated, color-keyed sprite renderer driving an external sync ROM
module sprite_drawer
  import video_pkg::*;
#(
  parameter int SPR_W       = 68,
  parameter int SPR_H       = 59,
  parameter int FRAMES      = 4,
  parameter int COLOR_W     = COLOR_W_DEFAULT,
  parameter int TRANSPARENT = 0,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W      = clog2_min1(SPR_W * SPR_H * FRAMES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [HV_W-1:0]               hcount,
  input  logic [HV_W-1:0]               vcount,
  input  logic [HV_W-1:0]               pos_x,
  input  logic [HV_W-1:0]               pos_y,
  input  logic                          enable,
  input  logic                          flip_h,
  input  logic                          anim_en,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [COLOR_W-1:0]            rom_data,
  output logic [COLOR_W-1:0]            pixel,
  output logic                          draw,
  output logic [clog2_min1(FRAMES)-1:0] frame_idx
);

  localparam int AW1      = ADDR_W + 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam logic [COLOR_W-1:0] KEY = COLOR_W'(TRANSPARENT);

  sprite_shadow_t shadow_q, shadow_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic               draw_q, draw_d;

  logic [10:0]    h_ext, v_ext, x_ext, y_ext, col, row;
  logic           in_box;
  logic [AW1-1:0] addr_full;

  sprite_anim_counter #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_anim (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .frame_idx   (frame_idx)
  );

  // Hit test in 11 bits so a box hanging past column/line 1023 clips instead of wrapping.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_start) begin
      shadow_d = '{x: pos_x, y: pos_y, en: enable, flip: flip_h};
    end

    h_ext = {1'b0, hcount};
    v_ext = {1'b0, vcount};
    x_ext = {1'b0, shadow_q.x};
    y_ext = {1'b0, shadow_q.y};

    in_box = shadow_q.en &&
             (h_ext >= x_ext) && (h_ext < x_ext + 11'(SPR_W)) &&
             (v_ext >= y_ext) && (v_ext < y_ext + 11'(SPR_H));

    col = h_ext - x_ext;
    if (shadow_q.flip) begin
      col = 11'(SPR_W - 1) - col;
    end
    row = v_ext - y_ext;

    addr_full = AW1'(frame_idx) * AW1'(FRAME_SZ) + AW1'(row) * AW1'(SPR_W) + AW1'(col);

    rom_addr_d = in_box ? ADDR_W'(addr_full) : '0;
    v1_d       = in_box;
    v2_d       = v1_q;
    draw_d     = v2_q && (rom_data != KEY);
    pixel_d    = draw_d ? rom_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      pixel_q    <= '0;
      draw_q     <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      pixel_q    <= pixel_d;
      draw_q     <= draw_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel    = pixel_q;
  assign draw     = draw_q;

endmodule
